// File: rtl/xadc_drp_scheduler.sv
// Schedules all XADC DRP reads: PWM-phase-aligned signal reads (ON/OFF tagged) plus a low-priority aux requester.
// One DRP access in flight at a time; signal requests outrank aux, aux reads are never preempted.
module xadc_drp_scheduler #(
   parameter logic [6:0] SIG_ADDR       = 7'h10,
   parameter int         SETTLE_CYCLES  = 1000,
   parameter int         TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pwm_in,
   input  logic        eoc_in,
   output logic        drp_den,
   output logic [6:0]  drp_daddr,
   input  logic [15:0] drp_do,
   input  logic        drp_drdy,
   input  logic        aux_req,
   input  logic [6:0]  aux_addr,
   output logic        aux_ack,
   output logic [15:0] aux_data,
   output logic [11:0] on_sample,
   output logic [11:0] off_sample,
   output logic        pair_valid,
   output logic [11:0] denoise,
   output logic        timeout_err
);

   localparam int SW = $clog2(SETTLE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, WAIT_EOC, SIG_READ, AUX_READ} state_t;

   state_t        state, state_nxt;
   logic          pwm_s1, pwm_s2, pwm_prev;
   logic          pwm_edge;
   logic [SW-1:0] settle_cnt;
   logic          settling, settle_done;
   logic          phase;
   logic          sig_pending, sig_tag;
   logic          rd_tag;
   logic [TW-1:0] tcnt;
   logic          tmo_hit, in_read;
   logic          issue_sig, issue_aux, rd_done, rd_tmo;
   logic          cap_on, cap_off;
   logic          have_on, have_off, pair_now;

   assign pwm_edge    = pwm_s2 ^ pwm_prev;
   // A fresh edge on the expiry cycle restarts the settle window instead of arming.
   assign settle_done = settling && (settle_cnt == '0) && !pwm_edge;
   assign in_read     = (state == SIG_READ) || (state == AUX_READ);
   assign tmo_hit     = (tcnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (sig_pending)             state_nxt = WAIT_EOC;
            else if (aux_req && !aux_ack) state_nxt = AUX_READ;
         end
         WAIT_EOC: if (eoc_in) state_nxt = SIG_READ;
         SIG_READ, AUX_READ: if (drp_drdy || tmo_hit) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // aux_ack gates a re-issue while the requester is still dropping aux_req.
   always_comb begin
      issue_sig = (state == WAIT_EOC) && eoc_in;
      issue_aux = (state == IDLE) && !sig_pending && aux_req && !aux_ack;
      rd_done   = in_read && drp_drdy;
      rd_tmo    = in_read && !drp_drdy && tmo_hit;
      cap_on    = rd_done && (state == SIG_READ) && rd_tag;
      cap_off   = rd_done && (state == SIG_READ) && !rd_tag;
      pair_now  = have_on && have_off;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pwm_s1      <= 1'b0;
         pwm_s2      <= 1'b0;
         pwm_prev    <= 1'b0;
         settle_cnt  <= '0;
         settling    <= 1'b0;
         phase       <= 1'b0;
         sig_pending <= 1'b0;
         sig_tag     <= 1'b0;
         rd_tag      <= 1'b0;
         tcnt        <= '0;
         drp_den     <= 1'b0;
         drp_daddr   <= '0;
         timeout_err <= 1'b0;
         aux_ack     <= 1'b0;
         aux_data    <= '0;
         on_sample   <= '0;
         off_sample  <= '0;
         have_on     <= 1'b0;
         have_off    <= 1'b0;
         pair_valid  <= 1'b0;
         denoise     <= '0;
      end else begin
         pwm_s1   <= pwm_in;
         pwm_s2   <= pwm_s1;
         pwm_prev <= pwm_s2;

         if (pwm_edge) begin
            settle_cnt <= SW'(SETTLE_CYCLES);
            settling   <= 1'b1;
            phase      <= pwm_s2;
         end else if (settling) begin
            if (settle_cnt == '0) settling   <= 1'b0;
            else                  settle_cnt <= settle_cnt - 1'b1;
         end

         if (settle_done) begin
            sig_pending <= 1'b1;
            sig_tag     <= phase;
         end else if (issue_sig) begin
            sig_pending <= 1'b0;
         end

         drp_den <= issue_sig || issue_aux;
         if (issue_sig)      drp_daddr <= SIG_ADDR;
         else if (issue_aux) drp_daddr <= aux_addr;
         if (issue_sig) rd_tag <= sig_tag;

         if (issue_sig || issue_aux)  tcnt <= '0;
         else if (in_read && !tmo_hit) tcnt <= tcnt + 1'b1;

         timeout_err <= rd_tmo;
         aux_ack     <= rd_done && (state == AUX_READ);
         if (rd_done && (state == AUX_READ)) aux_data <= drp_do;

         if (cap_on)  on_sample  <= drp_do[15:4];
         if (cap_off) off_sample <= drp_do[15:4];
         have_on  <= (have_on && !pair_now) || cap_on;
         have_off <= (have_off && !pair_now) || cap_off;

         pair_valid <= pair_now;
         if (pair_now) denoise <= (on_sample > off_sample) ? (on_sample - off_sample) : 12'd0;
      end
   end

endmodule

// File: tb/tb_xadc_drp_scheduler.sv
// Randomized bench for xadc_drp_scheduler: a transaction-level DRP responder/model checks every output each cycle.
module tb_xadc_drp_scheduler;
   localparam int S = 4;
   localparam int T = 8;
   localparam logic [6:0] SA = 7'h10;

   logic        clk = 1'b0, reset = 1'b1, pwm_in = 1'b0, eoc_in = 1'b0;
   logic        drp_drdy = 1'b0, aux_req = 1'b0;
   logic [15:0] drp_do = 16'h0;
   logic [6:0]  aux_addr = 7'h0;
   logic        drp_den, aux_ack, pair_valid, timeout_err;
   logic [6:0]  drp_daddr;
   logic [15:0] aux_data;
   logic [11:0] on_sample, off_sample, denoise;

   always #5 clk = ~clk;

   xadc_drp_scheduler #(.SIG_ADDR(SA), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .reset(reset), .pwm_in(pwm_in), .eoc_in(eoc_in),
      .drp_den(drp_den), .drp_daddr(drp_daddr), .drp_do(drp_do), .drp_drdy(drp_drdy),
      .aux_req(aux_req), .aux_addr(aux_addr), .aux_ack(aux_ack), .aux_data(aux_data),
      .on_sample(on_sample), .off_sample(off_sample), .pair_valid(pair_valid),
      .denoise(denoise), .timeout_err(timeout_err));

   typedef struct {
      logic [6:0]  addr;
      bit          sig;
      bit          tag;
      logic [15:0] data;
      bit          drop;
      int          dly;
   } rd_t;

   rd_t         q[$];
   rd_t         cur;
   int          total = 0, bad = 0, n_done = 0, cnt = 0;
   logic [11:0] m_on = 0, m_off = 0, m_den = 0, pair_den = 0;
   logic [15:0] m_aux = 0;
   bit          have_on, have_off, pair_pend, cap_pend, busy, ign;
   bit          e_pair, e_ack, e_to;
   bit          rst_seen = 1'b1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   always @(posedge clk) rst_seen <= reset;

   // Model + DRP responder: one read in flight, capture visible the cycle after drdy, pair one cycle later.
   always @(negedge clk) begin
      e_pair = 0; e_ack = 0; e_to = 0;
      drp_drdy = 1'b0;
      drp_do = 16'($urandom);
      if (rst_seen) begin
         m_on = 0; m_off = 0; m_den = 0; m_aux = 0;
         have_on = 0; have_off = 0; pair_pend = 0; cap_pend = 0;
         q.delete();
         if (busy) ign = 1;
      end else begin
         if (pair_pend) begin
            e_pair = 1; m_den = pair_den; pair_pend = 0;
         end
         if (cap_pend) begin
            cap_pend = 0;
            n_done++;
            if (!cur.sig) begin
               m_aux = cur.data; e_ack = 1;
            end else if (cur.tag) begin
               m_on = cur.data[15:4]; have_on = 1;
            end else begin
               m_off = cur.data[15:4]; have_off = 1;
            end
            if (have_on && have_off) begin
               pair_pend = 1;
               pair_den  = (m_on > m_off) ? m_on - m_off : 12'd0;
               have_on = 0; have_off = 0;
            end
         end
      end
      if (busy) begin
         cnt++;
         if (cur.drop) begin
            if (cnt == T) begin
               busy = 0;
               if (!ign) e_to = 1;
               n_done++;
               ign = 0;
            end
         end else if (cnt == cur.dly) begin
            drp_drdy = 1'b1;
            drp_do   = cur.data;
            busy     = 0;
            if (ign) begin
               n_done++; ign = 0;
            end else cap_pend = 1;
         end
      end
      chk("on_sample", 32'(on_sample), 32'(m_on));
      chk("off_sample", 32'(off_sample), 32'(m_off));
      chk("denoise", 32'(denoise), 32'(m_den));
      chk("pair_valid", 32'(pair_valid), 32'(e_pair));
      chk("aux_ack", 32'(aux_ack), 32'(e_ack));
      chk("aux_data", 32'(aux_data), 32'(m_aux));
      chk("timeout_err", 32'(timeout_err), 32'(e_to));
      if (drp_den === 1'b1) begin
         chk("den_while_busy", 32'(busy), 0);
         chk("den_expected", 32'(q.size() > 0), 1);
         if (!busy && q.size() > 0) begin
            cur = q.pop_front();
            chk("daddr", 32'(drp_daddr), 32'(cur.addr));
            busy = 1; cnt = 0; ign = 0;
         end
      end
   end

   task automatic wait_done(input int target);
      for (int i = 0; i < 200; i++) begin
         if (n_done >= target) break;
         step(1);
      end
      chk("done_wait", 32'(n_done >= target), 1);
   endtask

   task automatic wait_ack();
      bit got = 0;
      for (int i = 0; i < 100; i++) begin
         step(1);
         if (aux_ack === 1'b1) begin
            got = 1; break;
         end
      end
      aux_req = 1'b0;
      chk("ack_wait", 32'(got), 1);
   endtask

   task automatic sig_op(input bit dbl, input bit drop, input logic [15:0] d, input int dly,
                         input bit w_aux, input logic [6:0] aa, input logic [15:0] ad);
      rd_t r;
      bit  nl;
      int  n0;
      n0 = n_done;
      nl = ~pwm_in;
      if (dbl) begin
         pwm_in = nl; step(2); nl = ~nl;
      end
      r.addr = SA; r.sig = 1; r.tag = nl; r.data = d; r.drop = drop; r.dly = dly;
      q.push_back(r);
      pwm_in = nl;
      if (w_aux) begin
         r.addr = aa; r.sig = 0; r.tag = 0; r.data = ad; r.drop = 0;
         r.dly = int'($urandom_range(1, T - 1));
         q.push_back(r);
         step(11);
         aux_req = 1'b1; aux_addr = aa;
         step(2);
      end else step(int'($urandom_range(12, 18)));
      eoc_in = 1'b1; step(1); eoc_in = 1'b0;
      if (w_aux) wait_ack();
      wait_done(n0 + (w_aux ? 2 : 1));
   endtask

   task automatic aux_op(input logic [6:0] aa, input logic [15:0] ad);
      rd_t r;
      int  n0;
      n0 = n_done;
      r.addr = aa; r.sig = 0; r.tag = 0; r.data = ad; r.drop = 0;
      r.dly = int'($urandom_range(1, T - 1));
      q.push_back(r);
      aux_req = 1'b1; aux_addr = aa;
      wait_ack();
      wait_done(n0 + 1);
   endtask

   task automatic reset_op();
      rd_t r;
      int  n0;
      n0 = n_done;
      r.addr = SA; r.sig = 1; r.tag = ~pwm_in; r.data = 16'hFFF0; r.drop = 0; r.dly = T - 1;
      q.push_back(r);
      pwm_in = ~pwm_in;
      step(14);
      eoc_in = 1'b1; step(1); eoc_in = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (busy) break;
         step(1);
      end
      step(1);
      reset = 1'b1; pwm_in = 1'b0;
      step(1);
      reset = 1'b0;
      wait_done(n0 + 1);
      step(2);
      chk("rst_on", 32'(on_sample), 0);
      chk("rst_off", 32'(off_sample), 0);
      chk("rst_den", 32'(denoise), 0);
      chk("rst_aux", 32'(aux_data), 0);
   endtask

   initial begin
      step(3);
      chk("init_den", 32'(drp_den), 0);
      chk("init_on", 32'(on_sample), 0);
      chk("init_pair", 32'(pair_valid), 0);
      reset = 1'b0;
      step(2);

      sig_op(0, 0, 16'hA000, 2, 0, 7'h0, 16'h0);
      step(3);
      chk("t1_on", 32'(on_sample), 32'h00000A00);
      chk("t1_den_nopair", 32'(denoise), 0);
      sig_op(0, 0, 16'h3000, 3, 0, 7'h0, 16'h0);
      step(3);
      chk("t2_off", 32'(off_sample), 32'h00000300);
      chk("t2_denoise", 32'(denoise), 32'h00000700);
      sig_op(0, 0, 16'h2000, 1, 0, 7'h0, 16'h0);
      sig_op(0, 0, 16'h5000, T - 1, 0, 7'h0, 16'h0);
      step(3);
      chk("t3_denoise", 32'(denoise), 0);
      chk("t3_on", 32'(on_sample), 32'h00000200);
      sig_op(1, 0, 16'h4560, 2, 0, 7'h0, 16'h0);
      step(3);
      chk("t4_off", 32'(off_sample), 32'h00000456);
      sig_op(0, 0, 16'h9870, 2, 1, 7'h00, 16'hBEEF);
      step(3);
      chk("t5_aux", 32'(aux_data), 32'h0000BEEF);
      chk("t5_denoise", 32'(denoise), 32'h00000531);
      sig_op(0, 1, 16'h1110, 0, 0, 7'h0, 16'h0);
      step(3);
      chk("t6_on", 32'(on_sample), 32'h00000987);
      chk("t6_off", 32'(off_sample), 32'h00000456);
      reset_op();

      for (int it = 0; it < 40; it++) begin
         int k;
         k = int'($urandom_range(0, 9));
         if (k < 4)      sig_op(0, 0, 16'($urandom), int'($urandom_range(1, T - 1)), 0, 7'h0, 16'h0);
         else if (k < 5) sig_op(1, 0, 16'($urandom), int'($urandom_range(1, T - 1)), 0, 7'h0, 16'h0);
         else if (k < 7) aux_op(7'($urandom), 16'($urandom));
         else if (k < 8) sig_op(0, 0, 16'($urandom), int'($urandom_range(1, T - 1)), 1,
                                7'($urandom), 16'($urandom));
         else if (k < 9) sig_op(0, 1, 16'($urandom), 0, 0, 7'h0, 16'h0);
         else            sig_op(0, 0, 16'($urandom), T - 1, 0, 7'h0, 16'h0);
         step(int'($urandom_range(0, 5)));
      end
      step(5);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

endmodule
